// File: rtl/mux_n_rr_if.sv
// mux_n_rr_if: channel and output stream signals for mux_n_rr
// in_last exists only when MUX_LOCK_EN is defined
interface mux_n_rr_if #(
  parameter int WIDTH = 3,
  parameter int CH = 4
);
  localparam int SELW = $clog2(CH);
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
`ifdef MUX_LOCK_EN
  logic [CH-1:0] in_last;
`endif
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_sel;
  logic out_valid;
  logic out_ready;
  modport slave (
    input in_data, in_valid, out_ready,
`ifdef MUX_LOCK_EN
    input in_last,
`endif
    output in_ready, out_data, out_sel, out_valid
  );
  modport master (
    output in_data, in_valid, out_ready,
`ifdef MUX_LOCK_EN
    output in_last,
`endif
    input in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_n_rr.sv
// mux_n_rr: N-to-1 stream mux, fixed or round-robin select, registered output
// MUX_LOCK_EN keeps a round-robin grant on one channel until its in_last beat
module mux_n_rr #(
  parameter int WIDTH = 3,
  parameter int CH = 4,
  localparam int SELW = $clog2(CH)
) (
  input logic clk,
  input logic rst,
  input logic mode,
  input logic [SELW-1:0] s,
  mux_n_rr_if.slave bus
);
  logic [WIDTH-1:0] ch_data [CH];
  logic [SELW-1:0] ptr, g, nxt;
  logic gv, load;
`ifdef MUX_LOCK_EN
  logic lock;
  logic [SELW-1:0] locked;
`endif
  assign load = !rst && (!bus.out_valid || bus.out_ready);
  assign nxt = (int'(g) == CH - 1) ? '0 : g + 1'b1;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    assign bus.in_ready[i] = load && gv && g == SELW'(i);
  end
  // descending scan: the lowest offset from ptr is written last and wins
  always_comb begin
    g = '0;
    gv = 1'b0;
    if (!mode) begin
      g = s;
      gv = int'(s) < CH && bus.in_valid[s];
    end else begin
      for (int k = CH - 1; k >= 0; k--)
        if (bus.in_valid[(int'(ptr) + k) % CH]) begin
          g = SELW'((int'(ptr) + k) % CH);
          gv = 1'b1;
        end
`ifdef MUX_LOCK_EN
      if (lock) begin
        g = locked;
        gv = bus.in_valid[locked];
      end
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sel <= '0;
      ptr <= '0;
`ifdef MUX_LOCK_EN
      lock <= 1'b0;
      locked <= '0;
`endif
    end else begin
`ifdef MUX_LOCK_EN
      if (!mode) lock <= 1'b0;
`endif
      if (load) begin
        bus.out_valid <= gv;
        if (gv) begin
          bus.out_data <= ch_data[g];
          bus.out_sel <= g;
`ifdef MUX_LOCK_EN
          if (mode) begin
            lock <= !bus.in_last[g];
            locked <= g;
            if (bus.in_last[g]) ptr <= nxt;
          end
`else
          if (mode) ptr <= nxt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_n_rr.sv
// tb_mux_n_rr: table-driven check of mux_n_rr plus reset and packet-lock sequences
module tb_mux_n_rr;
  logic clk = 1'b0;
  logic rst, mode;
  logic [1:0] s;
  int n_chk = 0;
  int n_fail = 0;
  mux_n_rr_if #(.WIDTH(3), .CH(4)) bus ();
  mux_n_rr #(.WIDTH(3), .CH(4)) dut (.clk(clk), .rst(rst), .mode(mode), .s(s), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic mode;
    logic [1:0] s;
    logic [3:0] valid;
    logic [11:0] data;
    logic ordy;
    logic [3:0] ir;
    logic ov;
    logic [2:0] od;
    logic [1:0] os;
  } vec_t;
  localparam logic [11:0] D1 = 12'h8D1;
  localparam logic [11:0] D2 = 12'h1F5;
  vec_t tbl [23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic ov, input logic [2:0] od, input logic [1:0] os);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, " out_data"}, 32'(bus.out_data), 32'(od));
    chk({tag, " out_sel"}, 32'(bus.out_sel), 32'(os));
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd0, 4'hF, D1, 1'b1, 4'b0001, 1'b1, 3'd1, 2'd0};
    tbl[1]  = '{1'b1, 2'd0, 4'hF, D1, 1'b1, 4'b0010, 1'b1, 3'd2, 2'd1};
    tbl[2]  = '{1'b1, 2'd0, 4'hF, D1, 1'b1, 4'b0100, 1'b1, 3'd3, 2'd2};
    tbl[3]  = '{1'b1, 2'd0, 4'hF, D1, 1'b1, 4'b1000, 1'b1, 3'd4, 2'd3};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, D1, 1'b1, 4'b0001, 1'b1, 3'd1, 2'd0};
    tbl[5]  = '{1'b1, 2'd0, 4'hF, D1, 1'b1, 4'b0010, 1'b1, 3'd2, 2'd1};
    tbl[6]  = '{1'b0, 2'd2, 4'hF, D1, 1'b1, 4'b0100, 1'b1, 3'd3, 2'd2};
    tbl[7]  = '{1'b0, 2'd3, 4'hF, D1, 1'b1, 4'b1000, 1'b1, 3'd4, 2'd3};
    tbl[8]  = '{1'b0, 2'd1, 4'hD, D1, 1'b1, 4'b0000, 1'b0, 3'd4, 2'd3};
    tbl[9]  = '{1'b1, 2'd0, 4'h1, D1, 1'b1, 4'b0001, 1'b1, 3'd1, 2'd0};
    tbl[10] = '{1'b1, 2'd0, 4'h9, D1, 1'b1, 4'b1000, 1'b1, 3'd4, 2'd3};
    tbl[11] = '{1'b1, 2'd0, 4'h9, D1, 1'b1, 4'b0001, 1'b1, 3'd1, 2'd0};
    tbl[12] = '{1'b1, 2'd0, 4'h9, D1, 1'b1, 4'b1000, 1'b1, 3'd4, 2'd3};
    tbl[13] = '{1'b1, 2'd0, 4'h0, D1, 1'b1, 4'b0000, 1'b0, 3'd4, 2'd3};
    tbl[14] = '{1'b1, 2'd0, 4'hF, D2, 1'b1, 4'b0001, 1'b1, 3'd5, 2'd0};
    tbl[15] = '{1'b1, 2'd0, 4'hF, D2, 1'b0, 4'b0000, 1'b1, 3'd5, 2'd0};
    tbl[16] = '{1'b1, 2'd0, 4'hF, D2, 1'b0, 4'b0000, 1'b1, 3'd5, 2'd0};
    tbl[17] = '{1'b1, 2'd0, 4'hF, D2, 1'b0, 4'b0000, 1'b1, 3'd5, 2'd0};
    tbl[18] = '{1'b1, 2'd0, 4'hF, D2, 1'b1, 4'b0010, 1'b1, 3'd6, 2'd1};
    tbl[19] = '{1'b0, 2'd0, 4'hF, D2, 1'b1, 4'b0001, 1'b1, 3'd5, 2'd0};
    tbl[20] = '{1'b1, 2'd0, 4'hF, D2, 1'b1, 4'b0100, 1'b1, 3'd7, 2'd2};
    tbl[21] = '{1'b0, 2'd3, 4'hF, D2, 1'b0, 4'b0000, 1'b1, 3'd7, 2'd2};
    tbl[22] = '{1'b1, 2'd0, 4'h0, D2, 1'b1, 4'b0000, 1'b0, 3'd7, 2'd2};
    rst = 1'b1;
    mode = 1'b1;
    s = 2'd0;
    bus.in_data = D1;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
`ifdef MUX_LOCK_EN
    bus.in_last = 4'hF;
`endif
    tick();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("reset%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      chk_out($sformatf("reset%0d", c), 1'b0, 3'd0, 2'd0);
      tick();
    end
    rst = 1'b0;
    for (int v = 0; v < 23; v++) begin
      mode = tbl[v].mode;
      s = tbl[v].s;
      bus.in_valid = tbl[v].valid;
      bus.in_data = tbl[v].data;
      bus.out_ready = tbl[v].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", v), 32'(bus.in_ready), 32'(tbl[v].ir));
      tick();
      chk_out($sformatf("vec%0d", v), tbl[v].ov, tbl[v].od, tbl[v].os);
    end
    mode = 1'b1;
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    chk("pre_rst ptr3 in_ready", 32'(bus.in_ready), 32'b1000);
    tick();
    chk_out("pre_rst a", 1'b1, 3'd0, 2'd3);
    tick();
    chk_out("pre_rst b", 1'b1, 3'd5, 2'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk_out("mid_rst", 1'b0, 3'd0, 2'd0);
    rst = 1'b0;
    #1;
    chk("post_rst ptr0 in_ready", 32'(bus.in_ready), 32'b0001);
`ifdef MUX_LOCK_EN
    bus.in_data = D1;
    bus.in_valid = 4'b0110;
    bus.in_last = 4'b0000;
    #1;
    chk("lock beat0 in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("lock beat0", 1'b1, 3'd2, 2'd1);
    #1;
    chk("lock beat1 in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("lock beat1", 1'b1, 3'd2, 2'd1);
    bus.in_valid = 4'b0100;
    #1;
    chk("lock idle in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk_out("lock idle", 1'b0, 3'd2, 2'd1);
    bus.in_valid = 4'b0110;
    bus.in_last = 4'b0010;
    #1;
    chk("lock last in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("lock last", 1'b1, 3'd2, 2'd1);
    bus.in_last = 4'b1111;
    #1;
    chk("unlock in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("unlock", 1'b1, 3'd3, 2'd2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
